rv32m_div_unit: RTL and testbench



---
 rtl/rv32m_pkg.sv | 26 ++
 rtl/Han_Carlson_adder_32.sv | 46 ++++
 rtl/rv32m_div_unit_div_step.sv | 28 ++
 rtl/rv32m_div_unit.sv | 154 +++++++++++++++
 tb/tb_rv32m_div_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: operand width, funct3 op codes, divider states.
// Imported by the divider top level, its iteration step and the bench.
package rv32m_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/Han_Carlson_adder_32.sv
// 32-bit Han-Carlson parallel-prefix adder with carry in/out.
// Ports: a, b, cin -> sum, cout.
module Han_Carlson_adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    // Level 0: bitwise g/p, cin folded into bit 0.
    // Levels 1-5: Kogge-Stone on odd bits only.
    // Level 6: even bits pick up the carry of their odd neighbour.
    genvar l, i;
    for (l = 0; l <= 6; l++) begin : lv
        logic [31:0] g;
        logic [31:0] p;
        for (i = 0; i < 32; i++) begin : bt
            if (l == 0) begin : pg
                if (i == 0) begin : c0
                    assign g[i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cin);
                end else begin : cn
                    assign g[i] = a[i] & b[i];
                end
                assign p[i] = a[i] ^ b[i];
            end else if ((l == 1 && (i % 2) == 1) ||
                         (l >= 2 && l <= 5 && (i % 2) == 1
                          && i >= (1 << (l - 1))) ||
                         (l == 6 && (i % 2) == 0 && i >= 2)) begin : op
                localparam int D = (l >= 2 && l <= 5) ? (1 << (l - 1)) : 1;
                assign g[i] = lv[l-1].g[i] | (lv[l-1].p[i] & lv[l-1].g[i-D]);
                assign p[i] = lv[l-1].p[i] & lv[l-1].p[i-D];
            end else begin : pass
                assign g[i] = lv[l-1].g[i];
                assign p[i] = lv[l-1].p[i];
            end
        end
    end

    logic unused_p;
    assign unused_p = ^{lv[5].p, lv[6].p};

    assign sum  = lv[0].p ^ {lv[6].g[30:0], cin};
    assign cout = lv[6].g[31];

endmodule

// File: rtl/rv32m_div_unit_div_step.sv
// One radix-2 restoring division iteration (combinational).
// Ports: rem, quo, divisor -> rem_next, quo_next.
module div_step (
    input  logic [32:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [32:0] rem_next,
    output logic [31:0] quo_next
);

    logic [33:0] shifted;
    logic [33:0] trial;

    // quo still holds the unconsumed dividend bits; its MSB
    // shifts into the partial remainder each step.
    assign shifted = {rem, quo[31]};
    assign trial   = shifted - {2'b00, divisor};

    always_comb begin
        rem_next = trial[32:0];
        quo_next = {quo[30:0], 1'b1};
        if (trial[33]) begin
            rem_next = shifted[32:0];
            quo_next = {quo[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/rv32m_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, start/busy/done handshake.
// Ports: clk, rst, start, op, dividend, divisor -> busy, done, result.
module rv32m_div_unit
    import rv32m_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_t  state, state_d;
    logic [4:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic [1:0]  op_q;
    logic        q_neg;
    logic        r_neg;

    logic        is_signed, is_rem;
    logic        div_zero, ovf;
    logic        special, load, step, fix;
    logic [31:0] dvd_abs, dvs_abs;
    logic [31:0] spec_val;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] fix_sel, neg_sum, fix_val;
    logic        fix_neg;
    logic        neg_cout_unused;

    assign is_signed = op_is_signed(op);
    assign is_rem    = op_is_rem(op);
    assign div_zero  = (divisor == 32'd0);
    assign ovf       = is_signed && (dividend == 32'h8000_0000)
                       && (divisor == 32'hFFFF_FFFF);

    // 0x80000000 negates to itself, which reads correctly as 2^31.
    assign dvd_abs = (is_signed && dividend[31]) ? (~dividend + 32'd1)
                                                 : dividend;
    assign dvs_abs = (is_signed && divisor[31]) ? (~divisor + 32'd1)
                                                : divisor;

    always_comb begin
        spec_val = is_rem ? 32'd0 : 32'h8000_0000;
        if (div_zero) begin
            spec_val = is_rem ? dividend : 32'hFFFF_FFFF;
        end
    end

    div_step u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    assign fix_sel = op_is_rem(op_q) ? rem[31:0] : quo;
    assign fix_neg = op_is_rem(op_q) ? r_neg : q_neg;

    Han_Carlson_adder_32 u_neg (
        .a    (~fix_sel),
        .b    (32'd0),
        .cin  (1'b1),
        .sum  (neg_sum),
        .cout (neg_cout_unused)
    );

    assign fix_val = fix_neg ? neg_sum : fix_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        special = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (div_zero || ovf) begin
                        special = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                fix     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 5'd0;
            rem    <= 33'd0;
            quo    <= 32'd0;
            dvsr   <= 32'd0;
            op_q   <= 2'd0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
        end else begin
            done <= special | fix;
            if (special) begin
                result <= spec_val;
            end
            if (fix) begin
                result <= fix_val;
            end
            if (load) begin
                cnt   <= 5'd0;
                rem   <= 33'd0;
                quo   <= dvd_abs;
                dvsr  <= dvs_abs;
                op_q  <= op;
                q_neg <= is_signed & (dividend[31] ^ divisor[31]);
                r_neg <= is_signed & dividend[31];
            end
            if (step) begin
                rem <= rem_next;
                quo <= quo_next;
                cnt <= cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Self-checking bench for rv32m_div_unit: cycle model plus directed vectors.
// Drives after posedge, compares on negedge.
module tb_rv32m_div_unit;
    import rv32m_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    rv32m_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    function automatic logic is_special(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        if (b == 32'd0) return 1'b1;
        return !o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Architectural RV32M result.
    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic r, s;
        r = o[1];
        s = !o[0];
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return r ? 32'd0 : 32'h8000_0000;
        if (s) return r ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        return r ? a % b : a / b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle model: special ops finish at the sampling edge,
    // normal ops finish 33 edges after it; start ignored while pending.
    int          m_left = 0;
    logic [31:0] m_pend = 32'd0;
    logic        exp_done = 1'b0;
    logic        exp_busy = 1'b0;
    logic [31:0] exp_res = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left   = 0;
            exp_done = 1'b0;
            exp_busy = 1'b0;
            exp_res  = 32'd0;
        end else begin
            exp_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    exp_done = 1'b1;
                    exp_res  = m_pend;
                end
            end else if (start) begin
                if (is_special(op, dividend, divisor)) begin
                    exp_done = 1'b1;
                    exp_res  = model(op, dividend, divisor);
                end else begin
                    m_left = 33;
                    m_pend = model(op, dividend, divisor);
                end
            end
            exp_busy = (m_left > 0);
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("cyc_done", {31'd0, done}, {31'd0, exp_done});
        chk("cyc_result", result, exp_res);
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done, counting edges after the sampling edge E0.
    task automatic wait_done(input string name, input logic [31:0] exp,
                             input int lat, input int n0);
        int n;
        n = n0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done after %0d edges", name, n);
        end else begin
            chk({name, "_res"}, result, exp);
            chk({name, "_lat"}, n, lat);
        end
    endtask

    task automatic run(input string name, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
        @(posedge clk);
        #1;
        issue(o, a, b);
        wait_done(name, exp, lat, 0);
    endtask

    int ndone;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;

        chk("model_pin_div", model(OP_DIV, 32'hFFFF_FFF9, 32'd2),
            32'hFFFF_FFFD);
        chk("model_pin_rem", model(OP_REM, 32'd7, 32'hFFFF_FFFE), 32'd1);

        run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 0);
        run("divu_0_0", OP_DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 0);
        run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run("divu_big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run("remu_big", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 33);
        run("div_min_2", OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

        // Second start mid-operation must be ignored.
        @(posedge clk);
        #1;
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (4) @(posedge clk);
        #1;
        start    = 1'b1;
        op       = OP_DIVU;
        dividend = 32'd5;
        divisor  = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore_start", 32'd100, 33, 5);

        // Back-to-back: start raised in the done cycle.
        @(posedge clk);
        #1;
        issue(OP_REMU, 32'd1000, 32'd7);
        wait_done("b2b_first", 32'd6, 33, 0);
        issue(OP_DIVU, 32'd77, 32'd7);
        wait_done("b2b_second", 32'd11, 33, 0);

        // Abort with reset 10 clocks in.
        @(posedge clk);
        #1;
        issue(OP_DIVU, 32'd12345, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
